mod_mul_il_ctrl: RTL and testbench

Sequencer for one interleaved modular multiplication, r = a·b mod m, at radix 2^PBITS. It accepts a start request and first pulses the multiple-table generator so that it builds the i·b mod m table, then waits for the table to be ready. It then steps the accumulate/reduce datapath once per PBITS-wide digit of `a`, MSB first, runs a fixed number of final-correction cycles and signals completion. It sits between the top-level command interface and the table generator plus accumulator datapath.

---
 rtl/mod_mul_il_ctrl_if.sv | 34 +++
 rtl/mod_mul_il_ctrl.sv | 135 +++++++++++++
 tb/tb_mod_mul_il_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_il_ctrl_if.sv
// Command/datapath bundle for the interleaved modular multiply sequencer.
// master drives requests and table-ready; slave is the controller.
interface mod_mul_il_ctrl_if #(
  parameter int NBITS = 4096,
  parameter int PBITS = 1
);
  localparam int NDIG = NBITS / PBITS;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic             start;
  logic             abort;
  logic [NBITS-1:0] a;
  logic             pre_done;
  logic             busy;
  logic             done;
  logic             pre_en;
  logic             acc_clr;
  logic             step_en;
  logic [PBITS-1:0] digit;
  logic [IW-1:0]    dig_idx;
  logic             red_en;

  modport master (
    output start, abort, a, pre_done,
    input  busy, done, pre_en, acc_clr,
    input  step_en, digit, dig_idx, red_en
  );

  modport slave (
    input  start, abort, a, pre_done,
    output busy, done, pre_en, acc_clr,
    output step_en, digit, dig_idx, red_en
  );
endinterface

// File: rtl/mod_mul_il_ctrl.sv
// Sequencer for r = a*b mod m: table build, MSB-first digit steps,
// final correction, done pulse. All outputs registered.
module mod_mul_il_ctrl #(
  parameter int NBITS       = 4096,
  parameter int PBITS       = 1,
  parameter int FINAL_STEPS = 1
) (
  input logic clk,
  input logic rst,
  mod_mul_il_ctrl_if.slave bus
);
  localparam int NDIG = NBITS / PBITS;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW   = (FINAL_STEPS > 1) ? $clog2(FINAL_STEPS) : 1;

  if (NBITS % PBITS != 0) begin : g_bad_nbits
    $error("NBITS must be a multiple of PBITS");
  end
  if (FINAL_STEPS < 1) begin : g_bad_fin
    $error("FINAL_STEPS must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRE_ISSUE,
    PRE_WAIT,
    ITER,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]    fin_q, fin_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pre_q, pre_d;
  logic             step_q, step_d;
  logic             red_q, red_d;
  logic [PBITS-1:0] dig_q, dig_d;
  logic [IW-1:0]    idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          state_d = PRE_ISSUE;
        end
      end
      PRE_ISSUE: state_d = PRE_WAIT;
      PRE_WAIT: begin
        if (bus.pre_done) begin
          state_d = ITER;
          cnt_d   = IW'(NDIG - 1);
        end
      end
      ITER: begin
        a_d = a_q << PBITS;
        if (cnt_q == '0) begin
          state_d = FIN;
          fin_d   = FW'(FINAL_STEPS - 1);
        end else begin
          cnt_d = cnt_q - IW'(1);
        end
      end
      FIN: begin
        if (fin_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          fin_d = fin_q - FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // abort wins over everything except reset and leaves a_reg intact
    if (bus.abort) begin
      state_d = IDLE;
      a_d     = a_q;
      cnt_d   = cnt_q;
      fin_d   = fin_q;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
    pre_d  = (state_d == PRE_ISSUE);
    step_d = (state_d == ITER);
    red_d  = (state_d == FIN);
    dig_d  = step_d ? a_d[NBITS-1 -: PBITS] : '0;
    idx_d  = step_d ? cnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      fin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= 1'b0;
      step_q  <= 1'b0;
      red_q   <= 1'b0;
      dig_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      red_q   <= red_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pre_en  = pre_q;
  assign bus.acc_clr = pre_q;
  assign bus.step_en = step_q;
  assign bus.red_en  = red_q;
  assign bus.digit   = dig_q;
  assign bus.dig_idx = idx_q;
endmodule

// File: tb/tb_mod_mul_il_ctrl.sv
// Bench for mod_mul_il_ctrl (NBITS=8, PBITS=2, FINAL_STEPS=1):
// directed cycle table plus randomized runs against a timing model.
module tb_mod_mul_il_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mod_mul_il_ctrl_if #(.NBITS(8), .PBITS(2)) bus ();

  mod_mul_il_ctrl #(
    .NBITS(8),
    .PBITS(2),
    .FINAL_STEPS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      name;
    logic       r;
    logic       s;
    logic       ab;
    logic [7:0] a;
    logic       pd;
    logic [9:0] e;
  } vec_t;

  vec_t tv[$];

  function automatic logic [9:0] o(logic b, logic d, logic p, logic s,
                                   logic r, logic [1:0] dg, logic [1:0] ix);
    return {b, d, p, p, s, r, dg, ix};
  endfunction

  function automatic vec_t v(string n, logic r, logic s, logic ab,
                             logic [7:0] a, logic pd, logic [9:0] e);
    vec_t x;
    x.name = n; x.r = r; x.s = s; x.ab = ab;
    x.a = a; x.pd = pd; x.e = e;
    return x;
  endfunction

  function automatic logic [9:0] st(logic [1:0] dg, logic [1:0] ix);
    return o(1, 0, 0, 1, 0, dg, ix);
  endfunction

  localparam logic [9:0] ZZ  = 10'h000;
  localparam logic [9:0] DN  = 10'b0100000000;
  localparam logic [9:0] PRE = 10'b1011000000;
  localparam logic [9:0] BSY = 10'b1000000000;
  localparam logic [9:0] RED = 10'b1000010000;

  task automatic chk(input string nm, input logic [9:0] e);
    logic [9:0] act;
    act = {bus.busy, bus.done, bus.pre_en, bus.acc_clr, bus.step_en,
           bus.red_en, bus.digit, bus.dig_idx};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b (busy,done,pre,clr,step,red,dig,idx)",
               nm, act, e);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic ab,
                     input logic [7:0] av, input logic pd,
                     input logic [9:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r;
    bus.start = s;
    bus.abort = ab;
    bus.a = av;
    bus.pre_done = pd;
    @(negedge clk);
    chk(nm, e);
  endtask

  initial begin
    // nominal, start held high, back-to-back start on done with a=FF
    tv.push_back(v("nom_c0", 0, 1, 0, 8'hB4, 0, ZZ));
    tv.push_back(v("nom_c1", 0, 1, 0, 8'h00, 0, PRE));
    tv.push_back(v("nom_c2", 0, 1, 0, 8'h00, 0, BSY));
    tv.push_back(v("nom_c3", 0, 1, 0, 8'h00, 1, BSY));
    tv.push_back(v("nom_c4", 0, 1, 0, 8'h00, 0, st(2, 3)));
    tv.push_back(v("nom_c5", 0, 1, 0, 8'h00, 0, st(3, 2)));
    tv.push_back(v("nom_c6", 0, 1, 0, 8'h00, 0, st(1, 1)));
    tv.push_back(v("nom_c7", 0, 1, 0, 8'h00, 0, st(0, 0)));
    tv.push_back(v("nom_c8", 0, 1, 0, 8'h00, 0, RED));
    tv.push_back(v("nom_done", 0, 1, 0, 8'hFF, 0, DN));
    tv.push_back(v("b2b_pre", 0, 0, 0, 8'h00, 0, PRE));
    tv.push_back(v("b2b_wait", 0, 0, 0, 8'h00, 1, BSY));
    tv.push_back(v("b2b_s3", 0, 0, 0, 8'h00, 0, st(3, 3)));
    tv.push_back(v("b2b_s2", 0, 0, 0, 8'h00, 0, st(3, 2)));
    tv.push_back(v("b2b_s1", 0, 0, 0, 8'h00, 0, st(3, 1)));
    tv.push_back(v("b2b_s0", 0, 0, 0, 8'h00, 0, st(3, 0)));
    tv.push_back(v("b2b_red", 0, 0, 0, 8'h00, 0, RED));
    tv.push_back(v("b2b_done", 0, 0, 0, 8'h00, 0, DN));
    tv.push_back(v("b2b_idle", 0, 0, 0, 8'h00, 0, ZZ));
    // pre_done stuck high from cycle 0
    tv.push_back(v("stk_c0", 0, 1, 0, 8'hC6, 1, ZZ));
    tv.push_back(v("stk_pre", 0, 0, 0, 8'h00, 1, PRE));
    tv.push_back(v("stk_wait", 0, 0, 0, 8'h00, 1, BSY));
    tv.push_back(v("stk_s3", 0, 0, 0, 8'h00, 1, st(3, 3)));
    tv.push_back(v("stk_s2", 0, 0, 0, 8'h00, 1, st(0, 2)));
    tv.push_back(v("stk_s1", 0, 0, 0, 8'h00, 1, st(1, 1)));
    tv.push_back(v("stk_s0", 0, 0, 0, 8'h00, 1, st(2, 0)));
    tv.push_back(v("stk_red", 0, 0, 0, 8'h00, 1, RED));
    tv.push_back(v("stk_done", 0, 0, 0, 8'h00, 0, DN));
    tv.push_back(v("stk_idle", 0, 0, 0, 8'h00, 0, ZZ));
    // abort in 2nd ITER cycle, then abort blocking start, then 1B
    tv.push_back(v("ab_c0", 0, 1, 0, 8'hE4, 0, ZZ));
    tv.push_back(v("ab_pre", 0, 0, 0, 8'h00, 0, PRE));
    tv.push_back(v("ab_wait", 0, 0, 0, 8'h00, 1, BSY));
    tv.push_back(v("ab_s3", 0, 0, 0, 8'h00, 0, st(3, 3)));
    tv.push_back(v("ab_s2", 0, 0, 1, 8'h00, 0, st(2, 2)));
    tv.push_back(v("ab_idle", 0, 0, 0, 8'h00, 0, ZZ));
    tv.push_back(v("ab_nodone", 0, 1, 1, 8'hAA, 0, ZZ));
    tv.push_back(v("ab_block", 0, 1, 0, 8'h1B, 0, ZZ));
    tv.push_back(v("ab2_pre", 0, 0, 0, 8'h00, 0, PRE));
    tv.push_back(v("ab2_wait", 0, 0, 0, 8'h00, 1, BSY));
    tv.push_back(v("ab2_s3", 0, 0, 0, 8'h00, 0, st(0, 3)));
    tv.push_back(v("ab2_s2", 0, 0, 0, 8'h00, 0, st(1, 2)));
    tv.push_back(v("ab2_s1", 0, 0, 0, 8'h00, 0, st(2, 1)));
    tv.push_back(v("ab2_s0", 0, 0, 0, 8'h00, 0, st(3, 0)));
    tv.push_back(v("ab2_red", 0, 0, 0, 8'h00, 0, RED));
    tv.push_back(v("ab2_done", 0, 0, 0, 8'h00, 0, DN));
    // reset during FIN, then a normal run
    tv.push_back(v("rf_c0", 0, 1, 0, 8'hB4, 0, ZZ));
    tv.push_back(v("rf_pre", 0, 0, 0, 8'h00, 0, PRE));
    tv.push_back(v("rf_wait", 0, 0, 0, 8'h00, 1, BSY));
    tv.push_back(v("rf_s3", 0, 0, 0, 8'h00, 0, st(2, 3)));
    tv.push_back(v("rf_s2", 0, 0, 0, 8'h00, 0, st(3, 2)));
    tv.push_back(v("rf_s1", 0, 0, 0, 8'h00, 0, st(1, 1)));
    tv.push_back(v("rf_s0", 0, 0, 0, 8'h00, 0, st(0, 0)));
    tv.push_back(v("rf_red", 1, 0, 0, 8'h00, 0, RED));
    tv.push_back(v("rf_zero", 0, 0, 0, 8'h00, 0, ZZ));
    tv.push_back(v("rf_nodone", 0, 0, 0, 8'h00, 0, ZZ));
    tv.push_back(v("rf2_c0", 0, 1, 0, 8'hFF, 0, ZZ));
    tv.push_back(v("rf2_pre", 0, 0, 0, 8'h00, 0, PRE));
    tv.push_back(v("rf2_wait", 0, 0, 0, 8'h00, 1, BSY));
    tv.push_back(v("rf2_s3", 0, 0, 0, 8'h00, 0, st(3, 3)));
    tv.push_back(v("rf2_s2", 0, 0, 0, 8'h00, 0, st(3, 2)));
    tv.push_back(v("rf2_s1", 0, 0, 0, 8'h00, 0, st(3, 1)));
    tv.push_back(v("rf2_s0", 0, 0, 0, 8'h00, 0, st(3, 0)));
    tv.push_back(v("rf2_red", 0, 0, 0, 8'h00, 0, RED));
    tv.push_back(v("rf2_done", 0, 0, 0, 8'h00, 0, DN));
    tv.push_back(v("rf2_idle", 0, 0, 0, 8'h00, 0, ZZ));
  end

  initial begin
    automatic logic       pend = 1'b0;
    automatic logic [7:0] a_op;
    automatic int         p;
    automatic int         gap;
    automatic int         j;
    automatic logic [9:0] e;
    automatic logic       s;
    automatic logic       pd;

    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.a = 8'hB4;
    bus.pre_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", ZZ);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, ZZ, "post_reset");

    #0;
    for (int i = 0; i < tv.size(); i++)
      cyc(tv[i].r, tv[i].s, tv[i].ab, tv[i].a, tv[i].pd, tv[i].e, tv[i].name);

    // randomized operations checked against the documented timeline
    for (int k = 0; k < 20; k++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        cyc(0, 1'($urandom), 1, 8'($urandom), 1'($urandom),
            o(0, pend, 0, 0, 0, 0, 0), "rnd_gap");
        pend = 1'b0;
      end
      a_op = 8'($urandom);
      p = int'($urandom_range(1, 4));
      for (int t = 0; t <= 6 + p; t++) begin
        s  = (t == 0) ? 1'b1 : 1'($urandom);
        if (t >= 2 && t <= 1 + p) pd = (t == 1 + p);
        else pd = 1'($urandom);
        if (t == 0) e = o(0, pend, 0, 0, 0, 0, 0);
        else if (t == 1) e = PRE;
        else if (t <= 1 + p) e = BSY;
        else if (t <= 5 + p) begin
          j = t - 2 - p;
          e = st(2'((a_op >> (6 - 2 * j)) & 8'h3), 2'(3 - j));
        end else e = RED;
        cyc(0, s, 0, (t == 0) ? a_op : 8'($urandom), pd, e, "rnd_op");
        pend = 1'b0;
      end
      pend = 1'b1;
    end
    cyc(0, 0, 0, 8'h00, 0, o(0, pend, 0, 0, 0, 0, 0), "rnd_last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
